// File: rtl/hazard_pkg.sv
// Shared types and helpers for the hazard scoreboard: producer classes,
// per-class result latency and the countdown width.
package hazard_pkg;

  typedef enum logic [1:0] {
    P_ALU  = 2'd0,
    P_LOAD = 2'd1,
    P_MD   = 2'd2
  } prod_cls_e;

  // The reserved encoding 3 behaves as an ALU producer.
  function automatic prod_cls_e decode_cls(input logic [1:0] raw);
    case (raw)
      2'd1:    return P_LOAD;
      2'd2:    return P_MD;
      default: return P_ALU;
    endcase
  endfunction

  function automatic int lat_of(input prod_cls_e cls, input int load_lat, input int md_lat);
    case (cls)
      P_LOAD:  return load_lat + 1;
      P_MD:    return md_lat + 1;
      default: return 1;
    endcase
  endfunction

  function automatic int cnt_width(input int md_lat);
    return $clog2(md_lat + 2);
  endfunction

endpackage

// File: rtl/sb_countdown.sv
// Loadable down-counter that saturates at zero; a load wins over the decrement.
module sb_countdown #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] cnt
);

  // NOTE: sequential state uses non-blocking assignments so every counter
  // samples the same pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register countdown scoreboard driving PC / IF-ID write enables and the
// ID/EX bubble. Define HAZARD_PERF_EN to build the stall-cycle counter.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int  NUM_REGS = 32,
  parameter int  LOAD_LAT = 1,
  parameter int  MD_LAT   = 4,
  parameter int  BR_IN_ID = 1,
  localparam int RW       = $clog2(NUM_REGS)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs,
  input  logic [RW-1:0] id_rt,
  input  logic          id_use_rs,
  input  logic          id_use_rt,
  input  logic          id_is_branch,
  input  logic          id_wr_en,
  input  logic [RW-1:0] id_wr_reg,
  input  logic [1:0]    id_cls,
  input  logic          flush,
  output logic          pc_write,
  output logic          if_id_write,
  output logic          id_ex_bubble,
  output logic          md_busy,
  output logic [31:0]   perf_stall_cnt
);

  localparam int CW = cnt_width(MD_LAT);
  localparam logic [CW-1:0] BR_THR = (BR_IN_ID != 0) ? CW'(0) : CW'(1);

  logic [CW-1:0] c [NUM_REGS];
  logic [CW-1:0] m;
  logic [CW-1:0] lat;
  logic [CW-1:0] thr;
  prod_cls_e     cls;
  logic          raw, waw, structural;
  logic          stall, issue, wr_issue, md_issue;

  assign cls = decode_cls(id_cls);
  assign lat = CW'(lat_of(cls, LOAD_LAT, MD_LAT));

  // NOTE: every signal in this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    thr        = CW'(1);
    raw        = 1'b0;
    waw        = 1'b0;
    structural = 1'b0;
    if (id_is_branch) thr = BR_THR;
    if (id_use_rs && (c[id_rs] > thr)) raw = 1'b1;
    if (id_use_rt && (c[id_rt] > thr)) raw = 1'b1;
    // A younger fast producer must not retire before an older slow one.
    if (id_wr_en && (c[id_wr_reg] > lat)) waw = 1'b1;
    if ((cls == P_MD) && (m != '0)) structural = 1'b1;
  end

  assign stall    = id_valid & ~flush & (raw | waw | structural);
  assign issue    = id_valid & ~stall & ~flush;
  assign wr_issue = issue & id_wr_en;
  assign md_issue = issue & (cls == P_MD);

  assign pc_write     = ~stall;
  assign if_id_write  = ~stall;
  assign id_ex_bubble = stall | flush;
  assign md_busy      = (m != '0);

  // r0 is hard-wired clear, so it can never be marked or cause a hazard.
  assign c[0] = '0;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_reg
    sb_countdown #(.W(CW)) u_cnt (
      .clk      (clk),
      .rstn     (rstn),
      .load     (wr_issue && (id_wr_reg == RW'(r))),
      .load_val (lat),
      .cnt      (c[r])
    );
  end

  sb_countdown #(.W(CW)) u_md (
    .clk      (clk),
    .rstn     (rstn),
    .load     (md_issue),
    .load_val (CW'(MD_LAT)),
    .cnt      (m)
  );

`ifdef HAZARD_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      perf_q <= '0;
    end else if (stall && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_q;
`else
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: doc/hazard_scoreboard.md
Name: hazard_scoreboard

Overview:
Parametrised successor to the single-cycle load-use/branch stall detector.
- Keeps a per-register countdown scoreboard of in-flight producers: ALU, load, and multi-cycle mul/div.
- From the scoreboard it derives the stall, PC-write and IF/ID-write controls for the instruction in ID.
- Adds configurable load latency, branch-in-ID operand timing, WAW protection, a structural stall for the mul/div unit, and flush handling.
- Sits beside the ID stage and drives the PC, the IF/ID register and the ID/EX bubble mux.

Parameters:
NUM_REGS, 32, architectural register count; index width is RW = $clog2(NUM_REGS).
LOAD_LAT, 1, extra cycles after EX before load data can be forwarded; legal range 1..3.
MD_LAT, 4, mul/div execute cycles; legal range 2..16.
BR_IN_ID, 1, when 1, branches compare in ID and need operands one cycle earlier than EX consumers.

Ports:
clk  in  1  clock, rising-edge.
rstn  in  1  asynchronous active-low reset.
id_valid  in  1  ID holds a real instruction.
id_rs, id_rt  in  RW each  source register indices.
id_use_rs, id_use_rt  in  1 each  the corresponding source is actually read.
id_is_branch  in  1  ID instruction is a branch resolved in ID.
id_wr_en  in  1  ID instruction writes a register.
id_wr_reg  in  RW  destination register index.
id_cls  in  2  producer class: 0 = ALU, 1 = LOAD, 2 = MD; 3 is reserved and treated as ALU.
flush  in  1  kill the ID instruction (taken branch or redirect).
pc_write  out  1  PC may update.
if_id_write  out  1  IF/ID register may update.
id_ex_bubble  out  1  insert a NOP into ID/EX.
md_busy  out  1  mul/div unit occupied.
perf_stall_cnt  out  32  stall-cycle count (see Optional Feature).

Behaviour:
- Reset (rstn = 0, asynchronous): all counters cleared to 0. Outputs: pc_write = 1, if_id_write = 1, id_ex_bubble = 0, md_busy = 0, perf_stall_cnt = 0.
- State: one counter c[r] per register, width CW = $clog2(MD_LAT+2). One mul/div busy counter m, same width.
- Issue: issue = id_valid & ~stall & ~flush.
- On an issuing edge with id_wr_en = 1 and id_wr_reg != 0, load c[id_wr_reg] with L:
  - ALU: L = 1.
  - LOAD: L = LOAD_LAT + 1.
  - MD: L = MD_LAT + 1.
- Every edge: each nonzero c[r] not being loaded decrements by 1. A load overrides the decrement in the same cycle.
- Register 0 is never marked and never causes a hazard.
- RAW stall, per used source s:
  - Non-branch consumer: stall when c[s] > 1.
  - Branch consumer: stall when c[s] > (BR_IN_ID ? 0 : 1).
- WAW stall: id_wr_en and c[id_wr_reg] > L(id_cls). This prevents a younger fast producer from completing before an older slow one.
- Structural stall: id_cls = MD and m != 0. On an MD issue, m loads MD_LAT; m then decrements to 0. md_busy = (m != 0).
- stall = id_valid & ~flush & (RAW | WAW | structural).
- Outputs are combinational from the registered state and ID inputs:
  - pc_write = if_id_write = ~stall.
  - id_ex_bubble = stall | flush.
- Flush has priority over stall: pc_write = 1, if_id_write = 1, id_ex_bubble = 1, no issue. In-flight counters keep counting; producers already in EX and later stages remain valid.
- id_valid = 0: no stall, no issue, id_ex_bubble = 0.
- Counters never underflow; they saturate at 0.
- Reset asserted mid-operation clears all pending entries immediately.

Optional Feature:
HAZARD_PERF_EN
- Defined: perf_stall_cnt increments on every cycle with stall = 1 and saturates at 32'hFFFF_FFFF. It clears only on reset.
- Undefined: no counter logic is built; perf_stall_cnt is tied to 0.

Decomposition:
- Package hazard_pkg holds:
  - producer-class enum prod_cls_e {P_ALU, P_LOAD, P_MD};
  - the latency function lat_of(cls, LOAD_LAT, MD_LAT);
  - the count-width helper.
- Sub-module sb_countdown: one loadable saturating down-counter with async active-low reset. It is instantiated NUM_REGS-1 times via generate and once more for m.

Test Plan:
- Load to r8 issues; next cycle ID has add r9, r8, r1 with LOAD_LAT=1 -> exactly 1 stall cycle (bubble=1, pc_write=0), then it issues.
- ALU writes r5; next cycle beq r5, r6 with BR_IN_ID=1 -> 1 stall. Same test with a load producer -> 2 stalls.
- mul to r10 with MD_LAT=4; dependent add follows -> 4 stalls. A second mul issued immediately after -> stalls until md_busy=0.
- mul to r3 pending (c=5), then ALU write to r3 -> WAW stall until c[r3] <= 1.
- Dependent instruction stalling with flush=1 in the same cycle -> pc_write=1, bubble=1, r-counter keeps decrementing. Producers targeting r0 -> never stall.
- Reset mid-stall (rstn low 1 cycle) -> all outputs return to reset values; perf_stall_cnt=0 (HAZARD_PERF_EN). Three stall cycles afterward -> counter reads 3.
